start_input_conditioner: RTL and testbench
==========================================

Name: start_input_conditioner

Overview:
Front-end stage that drives the start/run inputs S and X of the one-hot T0/T1/T2 counting controller.
- Synchronises two raw asynchronous inputs (start button, run sensor) into the clock domain and debounces each.
- Delivers X as a clean debounced level.
- Delivers S as a single-cycle start pulse, issued only while the downstream controller reports idle (T0).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive mismatching samples required before a debounced level flips; legal range 1..2^CNT_WIDTH
CNT_WIDTH, 3, width of each per-channel debounce counter

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state on the next posedge
start_raw  input  1  asynchronous start button
x_raw  input  1  asynchronous run/sensor input
ctrl_idle  input  1  downstream controller is in T0; start pulses are allowed only while this is high
S  output  1  one-cycle start pulse to controller
X  output  1  debounced run level to controller
start_level  output  1  debounced start level, for observation and test

Behaviour:
- Reset (synchronous, active-high): on any posedge with reset=1, all of the following clear to 0:
  - synchroniser flops and debounce counters
  - debounced levels, S, X and start_level
  - The same applies mid-operation, with no residue.
- Synchroniser, per channel:
  - Two flops in series, sync1 <= raw, sync2 <= sync1.
  - Only sync2 feeds the debounce logic.
- Debounce, per channel (level register L, counter C):
  - If sync2 == L: C <= 0.
  - If sync2 != L and C == DEBOUNCE_CYCLES-1: L <= sync2, C <= 0.
  - Otherwise: C <= C+1.
  - Any sample that agrees with L restarts qualification (glitch rejection).
- Latency: raw changes before edge k and stays stable → L flips at edge k+1+DEBOUNCE_CYCLES (edge k+5 at default).
  - DEBOUNCE_CYCLES=1: L flips at edge k+2.
- Outputs: X = L of the x channel, start_level = L of the start channel; both registered, no combinational path from inputs.
- S generation:
  - At the edge where start L goes 0→1: S <= ctrl_idle as sampled at that edge.
  - On every other edge: S <= 0.
  - S is therefore high for exactly the first cycle of start_level=1, and never two consecutive cycles.
- Busy drop: if ctrl_idle=0 at the rising edge, the pulse is discarded, not queued.
  - A new pulse requires start_level to fall to 0 and re-qualify high.
- Held button: a continuously held start_raw yields exactly one pulse.
- Reset while held: if start_raw stays high across reset, start_level re-qualifies after full latency and a fresh S is issued (subject to ctrl_idle).
- Simultaneous events: the x and start channels are independent; both may flip on the same edge.
- Counter width: C never exceeds DEBOUNCE_CYCLES-1; no wrap is possible within the legal parameter range.

Decomposition:
- Shared package:
  - DEFAULT_DEBOUNCE_CYCLES = 4
  - DEFAULT_CNT_WIDTH = 3
  - SYNC_STAGES = 2, as a documented constant
- One sub-module, debounce_channel: synchroniser plus counter plus level register, with ports clock, reset, raw, level and rise.
  - rise is a one-cycle strobe on the edge where level goes 0→1.
  - Instantiated twice.
- Top level: ANDs the start channel's rise with ctrl_idle into the S register.

Test Plan:
- Reset hold: reset=1 for 3 edges with start_raw=1, x_raw=1 → S=0, X=0, start_level=0 throughout.
- Clean start: release reset, ctrl_idle=1, start_raw 0→1 before edge k, held → start_level=1 and S=1 from edge k+5, S=0 from edge k+6; no further S while held for 20 cycles.
- Glitch rejection: x_raw high for 3 cycles then low → X stays 0. Then x_raw high for 6 cycles → X=1 from edge k+5 and X=0 five edges after the fall.
- Busy drop: ctrl_idle=0 when start_level rises → S never asserts. Raising ctrl_idle later while the button is held → still no S. Release, re-press with ctrl_idle=1 → one S pulse.
- Reset mid-qualification: start_raw rises, reset asserted one edge at k+3 → start_level=0, counters cleared; S asserts at k+4+5 after release if start_raw is still held.
- DEBOUNCE_CYCLES=1 build: start_raw rise before edge k → S=1 at edge k+2 only; x_raw one-cycle pulse → X pulses for one cycle two edges later.

Source files
------------

// File: rtl/start_input_conditioner_pkg.sv
// Shared constants for the start/run input conditioner that feeds the T0/T1/T2 controller.
package start_input_conditioner_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_CNT_WIDTH       = 3;

    // Two-flop synchroniser depth for every asynchronous input channel.
    localparam int unsigned SYNC_STAGES             = 2;

endpackage

// File: rtl/start_input_conditioner_debounce_channel.sv
// One input channel: two-flop synchroniser, consecutive-mismatch counter and debounced level.
module debounce_channel
    import start_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with the current level restarts qualification.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    // High during the cycle whose closing edge flips the level 0->1.
    assign rise  = ~level_q & level_d;

endmodule

// File: rtl/start_input_conditioner.sv
// Conditions the raw start button and run sensor into S (one-shot start) and X (debounced run).
module start_input_conditioner
    import start_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic start_raw,
    input  logic x_raw,
    input  logic ctrl_idle,
    output logic S,
    output logic X,
    output logic start_level
);

    logic start_lvl, start_rise;
    logic x_lvl, x_rise;
    logic s_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_start_chan (
        .clock (clock),
        .reset (reset),
        .raw   (start_raw),
        .level (start_lvl),
        .rise  (start_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_x_chan (
        .clock (clock),
        .reset (reset),
        .raw   (x_raw),
        .level (x_lvl),
        .rise  (x_rise)
    );

    // A rise seen while the controller is busy is dropped, never queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= start_rise & ctrl_idle;
        end
    end

    assign S           = s_q;
    assign X           = x_lvl;
    assign start_level = start_lvl;

    logic unused_x_rise;
    assign unused_x_rise = x_rise;

endmodule

// File: tb/tb_start_input_conditioner.sv
// Randomised + directed bench for start_input_conditioner at DEBOUNCE_CYCLES=4 and =1.
module tb_start_input_conditioner;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_raw = 1'b0;
    logic x_raw = 1'b0;
    logic ctrl_idle = 1'b1;
    logic s4, x4, sl4, s1, x1, sl1;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state per instance [0]=D4, [1]=D1 and channel [0]=start, [1]=x.
    bit [1:0]  pipe [2][2];
    bit [15:0] hist [2][2];
    int        nval [2][2];
    bit        ml   [2][2];
    bit        ms   [2];

    always #5 clock = ~clock;

    start_input_conditioner u_dut4 (
        .clock       (clock),
        .reset       (reset),
        .start_raw   (start_raw),
        .x_raw       (x_raw),
        .ctrl_idle   (ctrl_idle),
        .S           (s4),
        .X           (x4),
        .start_level (sl4)
    );

    start_input_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .CNT_WIDTH       (1)
    ) u_dut1 (
        .clock       (clock),
        .reset       (reset),
        .start_raw   (start_raw),
        .x_raw       (x_raw),
        .ctrl_idle   (ctrl_idle),
        .S           (s1),
        .X           (x1),
        .start_level (sl1)
    );

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Level flips once the last d synchronised samples all disagree with it.
    task automatic model_step(input int i, input int d);
        bit raw, s2, old, flip;
        if (reset) begin
            ms[i] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                pipe[i][c] = '0;
                hist[i][c] = '0;
                nval[i][c] = 0;
                ml[i][c]   = 1'b0;
            end
            return;
        end
        for (int c = 0; c < 2; c++) begin
            raw = (c == 0) ? start_raw : x_raw;
            s2  = pipe[i][c][1];
            pipe[i][c] = {pipe[i][c][0], raw};
            hist[i][c] = {hist[i][c][14:0], s2};
            if (nval[i][c] < 16) nval[i][c]++;
            old  = ml[i][c];
            flip = (nval[i][c] >= d);
            for (int k = 0; k < d; k++) begin
                if (hist[i][c][k] == old) flip = 1'b0;
            end
            if (flip) ml[i][c] = ~old;
            if (c == 0) ms[i] = flip & ~old & ctrl_idle;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step(0, 4);
        model_step(1, 1);
        @(negedge clock);
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("S_d4", s4, ms[0]);
            check("X_d4", x4, ml[0][1]);
            check("start_level_d4", sl4, ml[0][0]);
            check("S_d1", s1, ms[1]);
            check("X_d1", x1, ml[1][1]);
            check("start_level_d1", sl1, ml[1][0]);
        end
    end

    initial begin
        // Reset hold with both raw inputs high.
        reset = 1'b1; start_raw = 1'b1; x_raw = 1'b1; ctrl_idle = 1'b1;
        steps(3);
        chk_en = 1'b1;
        check("reset_hold_S", s4, 1'b0);
        check("reset_hold_X", x4, 1'b0);
        check("reset_hold_level", sl4, 1'b0);
        reset = 1'b0; start_raw = 1'b0; x_raw = 1'b0;
        steps(8);

        // Clean start: press before edge k.
        start_raw = 1'b1;
        steps(2);
        check("d1_S_before_k2", s1, 1'b0);
        step();
        check("d1_S_at_k2", s1, 1'b1);
        check("d1_level_at_k2", sl1, 1'b1);
        step();
        check("d1_S_at_k3", s1, 1'b0);
        step();
        check("d4_level_at_k4", sl4, 1'b0);
        step();
        check("d4_S_at_k5", s4, 1'b1);
        check("d4_level_at_k5", sl4, 1'b1);
        step();
        check("d4_S_at_k6", s4, 1'b0);
        steps(20);
        check("held_no_repeat", s4, 1'b0);

        // Glitch rejection on x, then a qualified pulse.
        x_raw = 1'b1; steps(3);
        x_raw = 1'b0; steps(8);
        check("x_glitch_rejected", x4, 1'b0);
        x_raw = 1'b1; steps(5);
        check("x_before_k5", x4, 1'b0);
        step();
        check("x_at_k5", x4, 1'b1);
        x_raw = 1'b0; steps(5);
        check("x_still_high_k10", x4, 1'b1);
        step();
        check("x_low_k11", x4, 1'b0);

        // Busy drop.
        start_raw = 1'b0; steps(8);
        ctrl_idle = 1'b0; start_raw = 1'b1; steps(6);
        check("busy_level_up", sl4, 1'b1);
        check("busy_no_S", s4, 1'b0);
        ctrl_idle = 1'b1; steps(10);
        check("busy_late_idle_no_S", s4, 1'b0);
        start_raw = 1'b0; steps(8);
        start_raw = 1'b1; steps(6);
        check("repress_S", s4, 1'b1);
        step();
        check("repress_S_drop", s4, 1'b0);

        // Reset mid-qualification.
        start_raw = 1'b0; steps(8);
        start_raw = 1'b1; steps(3);
        reset = 1'b1; step();
        reset = 1'b0;
        check("midreset_level", sl4, 1'b0);
        steps(5);
        check("midreset_S_k8", s4, 1'b0);
        step();
        check("midreset_S_k9", s4, 1'b1);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) start_raw = ~start_raw;
            if ($urandom_range(5) == 0) x_raw = ~x_raw;
            ctrl_idle = ($urandom_range(3) != 0);
            reset = ($urandom_range(149) == 0);
            step();
        end
        reset = 1'b0;
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
